rf_write_buffer: RTL



---
 rtl/rf_write_buffer_if.sv | 76 +++++++
 rtl/rf_write_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rf_write_buffer_if.sv
// -----------------------------------------------------------------------------
// rf_write_buffer_if
//   Bundles every non-clock signal of the register-file write buffer.
//
//   Producer side (pipeline writeback, long-latency unit):
//     pipe_wen/pipe_wsel/pipe_wdat -> pipe_ready
//     lu_wen/lu_wsel/lu_wdat       -> lu_ready
//   Register file write port:
//     WEN, wsel, wdat
//   Forwarding lookup (decode):
//     q_rsel1/q_rsel2 -> q_hit1/q_hit2, q_dat1/q_dat2
//   Status:
//     count, full, empty
//
//   modport master : the environment around the buffer (producers, RF, decode)
//   modport slave  : the buffer itself
// -----------------------------------------------------------------------------
interface rf_write_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // pipeline writeback producer
    logic              pipe_wen;
    logic [REG_W-1:0]  pipe_wsel;
    logic [WORD_W-1:0] pipe_wdat;
    logic              pipe_ready;

    // long-latency unit producer
    logic              lu_wen;
    logic [REG_W-1:0]  lu_wsel;
    logic [WORD_W-1:0] lu_wdat;
    logic              lu_ready;

    // register file write port
    logic              WEN;
    logic [REG_W-1:0]  wsel;
    logic [WORD_W-1:0] wdat;

    // forwarding lookup
    logic [REG_W-1:0]  q_rsel1;
    logic [REG_W-1:0]  q_rsel2;
    logic              q_hit1;
    logic              q_hit2;
    logic [WORD_W-1:0] q_dat1;
    logic [WORD_W-1:0] q_dat2;

    // occupancy
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport master (
        output pipe_wen, pipe_wsel, pipe_wdat,
        input  pipe_ready,
        output lu_wen, lu_wsel, lu_wdat,
        input  lu_ready,
        input  WEN, wsel, wdat,
        output q_rsel1, q_rsel2,
        input  q_hit1, q_hit2, q_dat1, q_dat2,
        input  count, full, empty
    );

    modport slave (
        input  pipe_wen, pipe_wsel, pipe_wdat,
        output pipe_ready,
        input  lu_wen, lu_wsel, lu_wdat,
        output lu_ready,
        output WEN, wsel, wdat,
        input  q_rsel1, q_rsel2,
        output q_hit1, q_hit2, q_dat1, q_dat2,
        output count, full, empty
    );
endinterface

// File: rtl/rf_write_buffer.sv
// -----------------------------------------------------------------------------
// rf_write_buffer
//   Write buffer sitting directly in front of the register file. Collects
//   writes from the in-order pipeline and the long-latency unit, serialises
//   them onto the single RF write port (one per cycle, oldest first) and
//   offers a two-port forwarding lookup over the writes still pending.
//
//   Ports:
//     CLK  - clock, all state changes on the rising edge
//     RST  - synchronous active-high reset, discards all pending entries
//     bus  - rf_write_buffer_if.slave (producers, RF port, lookup, status)
//
//   Storage is a circular FIFO of {wsel, wdat}; head is the oldest entry.
//   Every entry is compared in parallel by the lookup, so the storage lives
//   in flops rather than a RAM.
// -----------------------------------------------------------------------------
module rf_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    rf_write_buffer_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ---------------------------------------------------------------- state
    logic [REG_W-1:0]  sel_mem_q [DEPTH];
    logic [REG_W-1:0]  sel_mem_d [DEPTH];
    logic [WORD_W-1:0] dat_mem_q [DEPTH];
    logic [WORD_W-1:0] dat_mem_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // ------------------------------------------------------- accept / drain
    logic [CNT_W-1:0]  space;
    logic              buf_empty;
    logic              buf_full;
    logic              pipe_ready;
    logic              lu_ready;
    logic              pipe_store;
    logic              lu_store;
    logic              pop;
    logic [PTR_W-1:0]  lu_idx;
    logic [1:0]        enq_count;

    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == CNT_W'(DEPTH));

    // Space comes from the registered count only: the entry being drained
    // this cycle is not counted as free, which keeps ready off the pop path.
    assign space      = CNT_W'(DEPTH) - count_q;
    assign pipe_ready = (space != '0);
    // The pipeline has priority for the last free slot.
    assign lu_ready   = (space >= CNT_W'(2)) ||
                        ((space == CNT_W'(1)) && !bus.pipe_wen);

    // Writes to r0 complete the handshake but never occupy a slot.
    assign pipe_store = bus.pipe_wen && pipe_ready && (bus.pipe_wsel != '0);
    assign lu_store   = bus.lu_wen   && lu_ready   && (bus.lu_wsel   != '0);
    assign pop        = !buf_empty;

    // The lu entry goes behind the pipeline entry when both are stored.
    assign lu_idx    = tail_q + PTR_W'(pipe_store);
    assign enq_count = {1'b0, pipe_store} + {1'b0, lu_store};

    always_comb begin
        sel_mem_d = sel_mem_q;
        dat_mem_d = dat_mem_q;
        valid_d   = valid_q;

        // Enqueue slots never coincide with the head being popped: a store
        // needs a free slot, and the tail only meets the head when empty.
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
        if (pipe_store) begin
            valid_d[tail_q]   = 1'b1;
            sel_mem_d[tail_q] = bus.pipe_wsel;
            dat_mem_d[tail_q] = bus.pipe_wdat;
        end
        if (lu_store) begin
            valid_d[lu_idx]   = 1'b1;
            sel_mem_d[lu_idx] = bus.lu_wsel;
            dat_mem_d[lu_idx] = bus.lu_wdat;
        end

        // Pointer arithmetic wraps naturally since DEPTH is a power of 2.
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(enq_count);
        count_d = count_q + CNT_W'(enq_count) - CNT_W'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: it is only observed through valid/count.
    always_ff @(posedge CLK) begin
        sel_mem_q <= sel_mem_d;
        dat_mem_q <= dat_mem_d;
    end

    // ----------------------------------------------------------- forwarding
    logic [DEPTH-1:0]  match1, match2;
    logic              hit1_raw, hit2_raw;
    logic [WORD_W-1:0] dat1_raw, dat2_raw;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match1[gi] = valid_q[gi] && (sel_mem_q[gi] == bus.q_rsel1);
        assign match2[gi] = valid_q[gi] && (sel_mem_q[gi] == bus.q_rsel2);
    end

    // Walk the entries from oldest (head) to youngest so the last match
    // seen is the youngest write to that register.
    always_comb begin
        hit1_raw = 1'b0;
        hit2_raw = 1'b0;
        dat1_raw = '0;
        dat2_raw = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match1[head_q + PTR_W'(k)]) begin
                hit1_raw = 1'b1;
                dat1_raw = dat_mem_q[head_q + PTR_W'(k)];
            end
            if (match2[head_q + PTR_W'(k)]) begin
                hit2_raw = 1'b1;
                dat2_raw = dat_mem_q[head_q + PTR_W'(k)];
            end
        end
    end

    logic fwd1_hit, fwd2_hit;

    // r0 is never stored, but the lookup still reports r0 as a miss
    // explicitly so decode never forwards into the zero register.
    assign fwd1_hit = !RST && (bus.q_rsel1 != '0) && hit1_raw;
    assign fwd2_hit = !RST && (bus.q_rsel2 != '0) && hit2_raw;

    assign bus.q_hit1 = fwd1_hit;
    assign bus.q_hit2 = fwd2_hit;
    assign bus.q_dat1 = fwd1_hit ? dat1_raw : '0;
    assign bus.q_dat2 = fwd2_hit ? dat2_raw : '0;

    // -------------------------------------------------------------- outputs
    logic rf_wen;

    // Reset suppresses the RF write in the very cycle it is asserted.
    assign rf_wen   = !RST && !buf_empty;
    assign bus.WEN  = rf_wen;
    assign bus.wsel = rf_wen ? sel_mem_q[head_q] : '0;
    assign bus.wdat = rf_wen ? dat_mem_q[head_q] : '0;

    assign bus.pipe_ready = pipe_ready;
    assign bus.lu_ready   = lu_ready;

    assign bus.count = RST ? '0 : count_q;
    assign bus.empty = RST || buf_empty;
    assign bus.full  = !RST && buf_full;

endmodule
